// File: rtl/seg_serial_display.sv
// Serial 7-segment chain driver: builds a text/graphic frame on start, then runs CLR, SHIFT, LATCH phases.
// Busy for (8*DIGITS+2)*2*CLK_DIV cycles; start is ignored while busy, and done pulses on return to IDLE.
module seg_serial_display #(
  parameter int DIGITS  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  text,
  input  logic                  flash,
  input  logic [4*DIGITS-1:0]   hexs,
  input  logic [DIGITS-1:0]     points,
  input  logic [DIGITS-1:0]     les,
  input  logic [8*DIGITS-1:0]   gfx,
  output logic                  segclk,
  output logic                  segsout,
  output logic                  segen,
  output logic                  segclrn,
  output logic                  busy,
  output logic                  done
);
  localparam int FW = 8 * DIGITS;
  localparam int PW = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam int BW = (FW > 1) ? $clog2(FW) : 1;

  typedef enum logic [1:0] {IDLE, CLR, SHIFT, LATCH} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   p_q, p_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [FW-1:0]   sh_q, sh_d;
  logic [FW-1:0]   frame;
  logic            segclk_q, segsout_q, segen_q, segclrn_q, busy_q, done_q;
  logic            last_phase;

  // Active-low segments in {g,f,e,d,c,b,a} order.
  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0: hex2seg = 7'h40;  4'h1: hex2seg = 7'h79;
      4'h2: hex2seg = 7'h24;  4'h3: hex2seg = 7'h30;
      4'h4: hex2seg = 7'h19;  4'h5: hex2seg = 7'h12;
      4'h6: hex2seg = 7'h02;  4'h7: hex2seg = 7'h78;
      4'h8: hex2seg = 7'h00;  4'h9: hex2seg = 7'h10;
      4'hA: hex2seg = 7'h08;  4'hB: hex2seg = 7'h03;
      4'hC: hex2seg = 7'h46;  4'hD: hex2seg = 7'h21;
      4'hE: hex2seg = 7'h06;  default: hex2seg = 7'h0E;
    endcase
  endfunction

  always_comb begin
    frame = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!text)                frame[8*i +: 8] = gfx[8*i +: 8];
      else if (les[i] && flash) frame[8*i +: 8] = 8'hFF;
      else                      frame[8*i +: 8] = {~points[i], hex2seg(hexs[4*i +: 4])};
    end
  end

  assign last_phase = (p_q == PW'(2 * CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    p_d     = last_phase ? '0 : p_q + PW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE: begin
        p_d = '0;
        if (start) begin
          state_d = CLR;
          sh_d    = frame;
        end
      end
      CLR: if (last_phase) begin
        state_d = SHIFT;
        bit_d   = '0;
      end
      SHIFT: if (last_phase) begin
        sh_d = {sh_q[FW-2:0], 1'b0};
        if (bit_q == BW'(FW - 1)) begin
          state_d = LATCH;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      LATCH: if (last_phase) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pins are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      p_q       <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      segclk_q  <= 1'b0;
      segsout_q <= 1'b1;
      segen_q   <= 1'b0;
      segclrn_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      segclk_q  <= (state_d == SHIFT) && (p_d >= PW'(CLK_DIV));
      segsout_q <= (state_d == SHIFT) ? sh_d[FW-1] : 1'b1;
      segen_q   <= (state_d == LATCH);
      segclrn_q <= (state_d != CLR);
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_q == LATCH) && (state_d == IDLE);
    end
  end

  assign segclk  = segclk_q;
  assign segsout = segsout_q;
  assign segen   = segen_q;
  assign segclrn = segclrn_q;
  assign busy    = busy_q;
  assign done    = done_q;
endmodule

// File: tb/tb_seg_serial_display.sv
// Directed bench: default 8-digit/div-2 instance for frame content, plus a 4-digit/div-1 instance for refresh timing.
module tb_seg_serial_display;
  logic clk = 1'b0;
  logic rst, start, text, flash;
  logic [31:0] hexs;
  logic [7:0]  points, les;
  logic [63:0] gfx;
  logic segclk, segsout, segen, segclrn, busy, done;

  logic start1;
  logic [15:0] hexs1;
  logic segclk1, segsout1, segen1, segclrn1, busy1, done1;

  int vec = 0;
  int miss = 0;

  always #5 clk = ~clk;

  seg_serial_display #(.DIGITS(8), .CLK_DIV(2)) u0 (
    .clk(clk), .rst(rst), .start(start), .text(text), .flash(flash),
    .hexs(hexs), .points(points), .les(les), .gfx(gfx),
    .segclk(segclk), .segsout(segsout), .segen(segen), .segclrn(segclrn),
    .busy(busy), .done(done));

  seg_serial_display #(.DIGITS(4), .CLK_DIV(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .text(1'b1), .flash(1'b0),
    .hexs(hexs1), .points(4'h0), .les(4'h0), .gfx(32'h0),
    .segclk(segclk1), .segsout(segsout1), .segen(segen1), .segclrn(segclrn1),
    .busy(busy1), .done(done1));

  // Pulses start, optionally pulses it again at cycle extra_at, and records the whole frame.
  task automatic run_frame(input int extra_at, output logic [63:0] bits,
                           output int nb, output int bc, output int sc, output int dc,
                           output int bad_seg);
    logic pclk;
    bits = '0; nb = 0; bc = 0; sc = 0; dc = 0; bad_seg = 0; pclk = 1'b0;
    start = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 300; c++) begin
      start = (c == extra_at);
      if (busy) bc++;
      if (segen) begin sc++; if (nb != 64) bad_seg = 1; end
      if (done) dc++;
      if (segclk && !pclk) begin bits = {bits[62:0], segsout}; nb++; end
      pclk = segclk;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_frame(input string name, input int extra_at, input logic [63:0] exp);
    logic [63:0] bits;
    int nb, bc, sc, dc, bad;
    run_frame(extra_at, bits, nb, bc, sc, dc, bad);
    vec++; if (bits !== exp) begin miss++; $display("FAIL %s bits got %h want %h", name, bits, exp); end
    vec++; if (nb != 64) begin miss++; $display("FAIL %s nbits got %0d want 64", name, nb); end
    vec++; if (bc != 264) begin miss++; $display("FAIL %s busy_cycles got %0d want 264", name, bc); end
    vec++; if (sc != 4) begin miss++; $display("FAIL %s segen_cycles got %0d want 4", name, sc); end
    vec++; if (dc != 1) begin miss++; $display("FAIL %s done_pulses got %0d want 1", name, dc); end
    vec++; if (bad != 0) begin miss++; $display("FAIL %s segen_before_last_bit got %0d want 0", name, bad); end
  endtask

  task automatic check_idle(input string name);
    vec++; if ({segclk, segsout, segen, segclrn, busy, done} !== 6'b010100) begin
      miss++; $display("FAIL %s u0 outputs got %b want 010100", name,
                       {segclk, segsout, segen, segclrn, busy, done});
    end
    vec++; if ({segclk1, segsout1, segen1, segclrn1, busy1, done1} !== 6'b010100) begin
      miss++; $display("FAIL %s u1 outputs got %b want 010100", name,
                       {segclk1, segsout1, segen1, segclrn1, busy1, done1});
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; start1 = 1'b0; text = 1'b1; flash = 1'b0;
    hexs = 32'h0123_4567; points = 8'h00; les = 8'h00; gfx = '0; hexs1 = 16'h1234;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_text;
    check_frame("text_0123_4567", -1, 64'hC0F9A4B0_999282F8);
    hexs = 32'h89AB_CDEF;
    check_frame("text_89AB_CDEF", -1, 64'h8090_8883_C6A1_868E);
  endtask

  task automatic test_points;
    hexs = 32'h0; points = 8'h01;
    check_frame("points_lsb", -1, 64'hC0C0C0C0_C0C0C040);
    points = 8'h00;
  endtask

  task automatic test_blink;
    hexs = 32'h0123_4567; les = 8'h80; flash = 1'b1;
    check_frame("blink_on", -1, 64'hFFF9A4B0_999282F8);
    flash = 1'b0;
    check_frame("blink_off", -1, 64'hC0F9A4B0_999282F8);
    les = 8'h00;
  endtask

  task automatic test_graphic;
    text = 1'b0; gfx = 64'hFFFF_FFFF_FFFF_FF00;
    check_frame("graphic", -1, 64'hFFFF_FFFF_FFFF_FF00);
    text = 1'b1;
  endtask

  // A second start mid-frame must not restart; inputs changed meanwhile must not leak in.
  task automatic test_start_while_busy;
    hexs = 32'h0123_4567;
    fork
      check_frame("start_while_busy", 50, 64'hC0F9A4B0_999282F8);
      begin repeat (20) @(negedge clk); hexs = 32'hFFFF_FFFF; end
    join
    hexs = 32'h0123_4567;
  endtask

  task automatic test_reset_mid_shift;
    int seg_seen, busy_seen;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("reset_mid_shift");
    rst = 1'b0;
    seg_seen = 0; busy_seen = 0;
    for (int c = 0; c < 300; c++) begin
      if (segen) seg_seen++;
      if (busy) busy_seen++;
      @(negedge clk);
    end
    vec++; if (seg_seen != 0) begin miss++; $display("FAIL reset_mid_shift segen_cycles got %0d want 0", seg_seen); end
    vec++; if (busy_seen != 0) begin miss++; $display("FAIL reset_mid_shift busy_cycles got %0d want 0", busy_seen); end
  endtask

  task automatic test_back_to_back;
    int t, n, rises, highs;
    logic p;
    logic [31:0] bits;
    start1 = 1'b1;
    t = 0;
    while (!busy1 && t < 10) begin @(negedge clk); t++; end
    vec++; if (busy1 !== 1'b1) begin miss++; $display("FAIL b2b busy_rise_timeout got %b want 1", busy1); end
    n = 0; rises = 0; highs = 0; p = 1'b0; bits = '0;
    while (busy1 && n < 200) begin
      n++;
      if (segclk1 && !p) begin rises++; bits = {bits[30:0], segsout1}; end
      if (segclk1) highs++;
      p = segclk1;
      @(negedge clk);
    end
    vec++; if (n != 68) begin miss++; $display("FAIL b2b busy_cycles got %0d want 68", n); end
    vec++; if (rises != 32) begin miss++; $display("FAIL b2b segclk_rises got %0d want 32", rises); end
    vec++; if (highs != 32) begin miss++; $display("FAIL b2b segclk_high_cycles got %0d want 32", highs); end
    vec++; if (bits !== 32'hF9A4B099) begin miss++; $display("FAIL b2b bits got %h want F9A4B099", bits); end
    vec++; if ({busy1, done1, segclrn1} !== 3'b011) begin
      miss++; $display("FAIL b2b gap_cycle busy,done,segclrn got %b want 011", {busy1, done1, segclrn1});
    end
    @(negedge clk);
    vec++; if ({busy1, done1, segclrn1} !== 3'b100) begin
      miss++; $display("FAIL b2b next_frame busy,done,segclrn got %b want 100", {busy1, done1, segclrn1});
    end
    start1 = 1'b0;
    repeat (80) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_text;
    test_points;
    test_blink;
    test_graphic;
    test_start_while_busy;
    test_reset_mid_shift;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
